// File: rtl/jvm_insn_parser.sv
// Streaming JVM bytecode parser: one byte in per handshake, one assembled instruction,
// switch header or jump-table entry out per handshake.
module jvm_insn_parser #(
  parameter int unsigned MAX_OPERANDS = 12,
  parameter int unsigned PC_W         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [PC_W-1:0]                      flush_pc,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_byte,
  output logic                                 op_valid,
  input  logic                                 op_ready,
  output logic [7:0]                           op_opcode,
  output logic [8*MAX_OPERANDS-1:0]            op_operands,
  output logic [$clog2(MAX_OPERANDS+1)-1:0]    op_count,
  output logic [PC_W-1:0]                      op_pc,
  output logic                                 op_wide,
  output logic [1:0]                           op_kind,
  output logic                                 op_err
);

  localparam int unsigned CW = $clog2(MAX_OPERANDS + 1);

  localparam logic [7:0] OpWide   = 8'hC4;
  localparam logic [7:0] OpTable  = 8'hAA;
  localparam logic [7:0] OpLookup = 8'hAB;

  localparam logic [1:0] KindInsn  = 2'd0;
  localparam logic [1:0] KindHdr   = 2'd1;
  localparam logic [1:0] KindEntry = 2'd2;

  typedef enum logic [2:0] {
    StOpc, StWideOpc, StPad, StOper, StEmit, StTbl, StTemit
  } state_e;

  function automatic logic [3:0] norm_len(input logic [7:0] opc);
    case (opc) inside
      8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC: norm_len = 4'd1;
      8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8], 8'hBB, 8'hBD,
      8'hC0, 8'hC1, 8'hC6, 8'hC7:                                norm_len = 4'd2;
      8'hC5:                                                     norm_len = 4'd3;
      8'hB9, 8'hBA, 8'hC8, 8'hC9:                                norm_len = 4'd4;
      default:                                                   norm_len = 4'd0;
    endcase
  endfunction

  // Zero means the opcode may not follow a wide prefix.
  function automatic logic [3:0] wide_len(input logic [7:0] opc);
    case (opc) inside
      8'h84:                                     wide_len = 4'd4;
      [8'h15:8'h19], [8'h36:8'h3A], 8'hA9:       wide_len = 4'd2;
      default:                                   wide_len = 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] be32(input logic [8*MAX_OPERANDS-1:0] v,
                                       input int unsigned k);
    be32 = {v[8*k +: 8], v[8*(k+1) +: 8], v[8*(k+2) +: 8], v[8*(k+3) +: 8]};
  endfunction

  state_e                      state_q;
  logic [PC_W-1:0]             pc_q;
  logic [PC_W-1:0]             insn_pc_q;
  logic [7:0]                  opc_q;
  logic                        wide_q;
  logic [1:0]                  kind_q;
  logic [CW-1:0]               len_q;
  logic [CW-1:0]               cnt_q;
  logic [1:0]                  pad_q;
  logic [8*MAX_OPERANDS-1:0]   buf_q;
  logic [31:0]                 entries_q;

  logic                        accept;
  logic [CW-1:0]               cnt_inc;
  logic [8*MAX_OPERANDS-1:0]   buf_ins;
  logic [3:0]                  nlen;
  logic [3:0]                  wlen;
  logic                        is_switch;
  logic signed [31:0]          hdr_entries;

  logic                        em_go;
  logic [7:0]                  em_opcode;
  logic [8*MAX_OPERANDS-1:0]   em_ops;
  logic [CW-1:0]               em_count;
  logic [PC_W-1:0]             em_pc;
  logic                        em_wide;
  logic [1:0]                  em_kind;
  logic                        em_err;

  assign in_ready  = !rst && (state_q inside {StOpc, StWideOpc, StPad, StOper, StTbl});
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CW'(1);
  assign nlen      = norm_len(in_byte);
  assign wlen      = wide_len(in_byte);
  assign is_switch = (in_byte == OpTable) || (in_byte == OpLookup);

  // Entry count of the switch header currently being presented.
  assign hdr_entries = (op_opcode == OpTable) ?
                       (be32(op_operands, 8) - be32(op_operands, 4) + 32'd1) :
                       be32(op_operands, 4);

  always_comb begin
    buf_ins = buf_q;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      if (cnt_q == CW'(i)) buf_ins[8*i +: 8] = in_byte;
    end
  end

  // Beat to load when the current byte completes something.
  always_comb begin
    em_go     = 1'b0;
    em_opcode = opc_q;
    em_ops    = buf_ins;
    em_count  = len_q;
    em_pc     = insn_pc_q;
    em_wide   = wide_q;
    em_kind   = kind_q;
    em_err    = 1'b0;
    if (accept) begin
      unique case (state_q)
        StOpc: begin
          if (in_byte != OpWide && !is_switch && nlen == 4'd0) begin
            em_go     = 1'b1;
            em_opcode = in_byte;
            em_ops    = '0;
            em_count  = '0;
            em_pc     = pc_q;
            em_wide   = 1'b0;
            em_kind   = KindInsn;
          end
        end
        StWideOpc: begin
          if (wlen == 4'd0) begin
            em_go     = 1'b1;
            em_opcode = in_byte;
            em_ops    = '0;
            em_count  = '0;
            em_err    = 1'b1;
          end
        end
        StOper, StTbl: em_go = (cnt_inc == len_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StOpc;
      pc_q        <= '0;
      insn_pc_q   <= '0;
      opc_q       <= '0;
      wide_q      <= 1'b0;
      kind_q      <= KindInsn;
      len_q       <= '0;
      cnt_q       <= '0;
      pad_q       <= '0;
      buf_q       <= '0;
      entries_q   <= '0;
      op_valid    <= 1'b0;
      op_opcode   <= '0;
      op_operands <= '0;
      op_count    <= '0;
      op_pc       <= '0;
      op_wide     <= 1'b0;
      op_kind     <= KindInsn;
      op_err      <= 1'b0;
    end else if (flush) begin
      state_q  <= StOpc;
      pc_q     <= flush_pc;
      op_valid <= 1'b0;
      cnt_q    <= '0;
      buf_q    <= '0;
    end else begin
      if (accept) pc_q <= pc_q + PC_W'(1);
      unique case (state_q)
        StOpc: begin
          if (accept) begin
            insn_pc_q <= pc_q;
            opc_q     <= in_byte;
            wide_q    <= 1'b0;
            kind_q    <= KindInsn;
            cnt_q     <= '0;
            buf_q     <= '0;
            if (in_byte == OpWide) begin
              wide_q  <= 1'b1;
              state_q <= StWideOpc;
            end else if (is_switch) begin
              kind_q  <= KindHdr;
              len_q   <= (in_byte == OpTable) ? CW'(12) : CW'(8);
              // Header is 4-byte aligned: pad = (-(pc+1)) mod 4.
              pad_q   <= ~pc_q[1:0];
              state_q <= (pc_q[1:0] == 2'b11) ? StOper : StPad;
            end else begin
              len_q   <= CW'(nlen);
              state_q <= StOper;
            end
          end
        end
        StWideOpc: begin
          if (accept) begin
            opc_q   <= in_byte;
            len_q   <= CW'(wlen);
            state_q <= StOper;
          end
        end
        StPad: begin
          if (accept) begin
            pad_q <= pad_q - 2'd1;
            if (pad_q == 2'd1) state_q <= StOper;
          end
        end
        StOper, StTbl: begin
          if (accept) begin
            buf_q <= buf_ins;
            cnt_q <= cnt_inc;
          end
        end
        StEmit: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            cnt_q    <= '0;
            buf_q    <= '0;
            if (kind_q == KindHdr && hdr_entries > 32'sd0) begin
              entries_q <= hdr_entries;
              kind_q    <= KindEntry;
              len_q     <= (opc_q == OpTable) ? CW'(4) : CW'(8);
              state_q   <= StTbl;
            end else begin
              state_q <= StOpc;
            end
          end
        end
        StTemit: begin
          if (op_ready) begin
            op_valid  <= 1'b0;
            cnt_q     <= '0;
            buf_q     <= '0;
            entries_q <= entries_q - 32'd1;
            state_q   <= (entries_q != 32'd1) ? StTbl : StOpc;
          end
        end
        default: state_q <= StOpc;
      endcase
      if (em_go) begin
        op_valid    <= 1'b1;
        op_opcode   <= em_opcode;
        op_operands <= em_ops;
        op_count    <= em_count;
        op_pc       <= em_pc;
        op_wide     <= em_wide;
        op_kind     <= em_kind;
        op_err      <= em_err;
        state_q     <= (state_q == StTbl) ? StTemit : StEmit;
      end
    end
  end

endmodule
